// File: rtl/alu_flags_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_flags_pkg
// Description : Shared types for the ALU flag stream and branch resolution:
//               condition codes, the {v, n, c, z} flag word and the branch
//               resolver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_flags_pkg;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_Z      = 3'b001,
        COND_NZ     = 3'b010,
        COND_C      = 3'b011,
        COND_NC     = 3'b100,
        COND_N      = 3'b101,
        COND_V      = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    typedef struct packed {
        logic v;
        logic n;
        logic c;
        logic z;
    } flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } brs_state_e;

endpackage : alu_flags_pkg
`default_nettype wire

// File: rtl/alu_branch_resolver_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational branch-condition evaluator.
//   cond  in  cond_e   condition code
//   flags in  flags_t  {v, n, c, z}
//   taken out 1        1 = condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import alu_flags_pkg::*;
(
    input  cond_e  cond,
    input  flags_t flags,
    output logic   taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = flags.z;
            COND_NZ:     taken = ~flags.z;
            COND_C:      taken = flags.c;
            COND_NC:     taken = ~flags.c;
            COND_N:      taken = flags.n;
            COND_V:      taken = flags.v;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/alu_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : alu_branch_resolver
// Description : Resolves conditional branches against the ALU flag stream.
//               Counts in-flight flag-writing ops and holds an accepted
//               branch until every older op has written its flags back.
//   clk, rst          clock, asynchronous active-high reset
//   alu_issue         flag-writing ALU op issued this cycle
//   flag_wr_valid     flag write-back from oldest in-flight op
//   flag_wr[3:0]      {v, n, c, z} written on flag_wr_valid
//   br_valid/ready    branch request handshake, br_cond[2:0] condition
//   res_valid/ready   result handshake, res_taken = branch taken
//   flags_q[3:0]      architectural flag register
//   pending_q         in-flight flag-writing ops
//   err_sticky[1:0]   {overflow, underflow}, sticky until reset
// Revision    : 1.0 - initial release
// ============================================================================
module alu_branch_resolver
    import alu_flags_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alu_issue,
    input  logic                               flag_wr_valid,
    input  logic [3:0]                         flag_wr,
    input  logic                               br_valid,
    input  logic [2:0]                         br_cond,
    output logic                               br_ready,
    output logic                               res_valid,
    output logic                               res_taken,
    input  logic                               res_ready,
    output logic [3:0]                         flags_q,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_q,
    output logic [1:0]                         err_sticky
);

    localparam int                c_pw  = $clog2(MAX_PENDING + 1);
    localparam logic [c_pw-1:0]   c_max = c_pw'(MAX_PENDING);
    localparam logic [c_pw-1:0]   c_one = c_pw'(1);

    brs_state_e       r_state,     w_state_next;
    logic [c_pw-1:0]  r_pending,   w_pending_next;
    logic [c_pw-1:0]  r_wait_cnt,  w_wait_cnt_next;
    cond_e            r_cond,      w_cond_next;
    logic             r_res_taken, w_res_taken_next;
    logic [1:0]       r_err,       w_err_next;
    flags_t           r_flags;
    logic             w_taken;

    cond_eval u_cond_eval (
        .cond  (r_cond),
        .flags (r_flags),
        .taken (w_taken)
    );

    // Pending-op counter; a simultaneous issue and write-back cancel out.
    always_comb begin
        w_pending_next = r_pending;
        w_err_next     = r_err;
        case ({alu_issue, flag_wr_valid})
            2'b10: begin
                if (r_pending == c_max) w_err_next[1] = 1'b1;
                else                    w_pending_next = r_pending + c_one;
            end
            2'b01: begin
                if (r_pending == '0) w_err_next[0] = 1'b1;
                else                 w_pending_next = r_pending - c_one;
            end
            default: ;
        endcase
    end

    // Branch FSM next-state and outputs.
    always_comb begin
        w_state_next     = r_state;
        w_wait_cnt_next  = r_wait_cnt;
        w_cond_next      = r_cond;
        w_res_taken_next = r_res_taken;
        br_ready         = 1'b0;
        res_valid        = 1'b0;
        case (r_state)
            IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    w_cond_next  = cond_e'(br_cond);
                    // A write-back in the accept cycle belongs to an older op,
                    // so it already counts toward what the branch waits for.
                    // A coincident issue is younger and is not counted.
                    if (flag_wr_valid && (r_pending != '0))
                        w_wait_cnt_next = r_pending - c_one;
                    else
                        w_wait_cnt_next = r_pending;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (r_wait_cnt == '0) begin
                    // r_flags is the pre-edge value, so a write landing this
                    // cycle comes from a younger op and is not seen here.
                    w_res_taken_next = w_taken;
                    w_state_next     = RESP;
                end else if (flag_wr_valid) begin
                    w_wait_cnt_next = r_wait_cnt - c_one;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_wait_cnt  <= '0;
            r_cond      <= COND_ALWAYS;
            r_res_taken <= 1'b0;
            r_err       <= 2'b00;
            r_flags     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pending_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_cond      <= w_cond_next;
            r_res_taken <= w_res_taken_next;
            r_err       <= w_err_next;
            if (flag_wr_valid) r_flags <= flags_t'(flag_wr);
        end
    end

    assign res_taken  = r_res_taken;
    assign flags_q    = r_flags;
    assign pending_q  = r_pending;
    assign err_sticky = r_err;

endmodule : alu_branch_resolver
`default_nettype wire

// File: tb/tb_alu_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_branch_resolver
// Description : Scoreboard testbench for alu_branch_resolver. Stimulus pushes
//               the expected result and its first-valid cycle; a monitor pops
//               and compares on every result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_branch_resolver;

    logic       clk;
    logic       rst;
    logic       alu_issue;
    logic       flag_wr_valid;
    logic [3:0] flag_wr;
    logic       br_valid;
    logic [2:0] br_cond;
    logic       br_ready;
    logic       res_valid;
    logic       res_taken;
    logic       res_ready;
    logic [3:0] flags_q;
    logic [2:0] pending_q;
    logic [1:0] err_sticky;

    alu_branch_resolver #(.MAX_PENDING(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_issue     (alu_issue),
        .flag_wr_valid (flag_wr_valid),
        .flag_wr       (flag_wr),
        .br_valid      (br_valid),
        .br_cond       (br_cond),
        .br_ready      (br_ready),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_ready     (res_ready),
        .flags_q       (flags_q),
        .pending_q     (pending_q),
        .err_sticky    (err_sticky)
    );

    typedef struct {
        logic taken;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total;
    int   bad;
    int   cyc;
    int   first_cyc;
    bit   prev_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got %0d outstanding want 0", sb.size());
            sb.delete();
        end
        step();
    endtask

    task automatic branch(input logic [2:0] c);
        chk("br_ready_idle", br_ready, 1);
        br_valid = 1'b1;
        br_cond  = c;
        step();
        br_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_br_ready"},  br_ready,   1);
        chk({tag, "_res_valid"}, res_valid,  0);
        chk({tag, "_res_taken"}, res_taken,  0);
        chk({tag, "_flags_q"},   flags_q,    0);
        chk({tag, "_pending_q"}, pending_q,  0);
        chk({tag, "_err"},       err_sticky, 0);
    endtask

    // Monitor: records the first cycle res_valid is seen, checks on handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid && !prev_v) first_cyc = cyc;
            prev_v = res_valid;
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got taken=%0d want no result", res_taken);
                end else begin
                    e = sb.pop_front();
                    chk("res_taken", res_taken, e.taken);
                    chk("res_first_cycle", first_cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; alu_issue = 0; flag_wr_valid = 0; flag_wr = '0;
        br_valid = 0; br_cond = '0; res_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk_reset_vals("reset");

        // Underflow write, then Z branch with nothing pending.
        flag_wr_valid = 1'b1; flag_wr = 4'b0001;
        step();
        flag_wr_valid = 1'b0;
        chk("uflow_err", err_sticky, 2'b01);
        chk("uflow_flags", flags_q, 4'b0001);
        chk("uflow_pending", pending_q, 0);
        branch(3'b001);
        sb.push_back('{1'b1, cyc + 1});
        wait_empty();

        // Three older ops pending; branch waits for all three write-backs.
        alu_issue = 1'b1;
        repeat (3) step();
        alu_issue = 1'b0;
        chk("issue3_pending", pending_q, 3);
        branch(3'b010);
        step(); step();
        chk("wait_br_ready", br_ready, 0);
        chk("wait_res_valid", res_valid, 0);
        flag_wr_valid = 1'b1; flag_wr = 4'b0000;
        step(); step();
        flag_wr = 4'b0001;
        step();
        flag_wr_valid = 1'b0;
        sb.push_back('{1'b0, cyc + 1});
        wait_empty();
        chk("drain_pending", pending_q, 0);

        // Clear Z, then branch together with a younger issue.
        alu_issue = 1'b1;
        step();
        alu_issue = 1'b0; flag_wr_valid = 1'b1; flag_wr = 4'b0000;
        step();
        flag_wr_valid = 1'b0;
        chk("clrz_flags", flags_q, 0);
        chk("clrz_pending", pending_q, 0);
        chk("br_ready_idle", br_ready, 1);
        br_valid = 1'b1; br_cond = 3'b010; alu_issue = 1'b1;
        step();
        br_valid = 1'b0; alu_issue = 1'b0;
        sb.push_back('{1'b1, cyc + 1});
        chk("young_pending", pending_q, 1);
        // Younger op's write lands in the evaluation cycle; must not be used.
        flag_wr_valid = 1'b1; flag_wr = 4'b0001;
        step();
        flag_wr_valid = 1'b0;
        wait_empty();
        chk("young_pending_after", pending_q, 0);
        chk("young_flags_after", flags_q, 4'b0001);

        // Back-pressure on the result.
        res_ready = 1'b0;
        branch(3'b000);
        sb.push_back('{1'b1, cyc + 1});
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_res_valid", res_valid, 1);
            chk("stall_res_taken", res_taken, 1);
            chk("stall_br_ready", br_ready, 0);
            step();
        end
        res_ready = 1'b1;
        wait_empty();
        chk("post_stall_br_ready", br_ready, 1);
        chk("post_stall_res_valid", res_valid, 0);

        // Saturation at MAX_PENDING.
        rst = 1'b1; step(); rst = 1'b0; step();
        alu_issue = 1'b1;
        repeat (4) step();
        chk("full_pending", pending_q, 4);
        chk("full_err", err_sticky, 0);
        flag_wr_valid = 1'b1; flag_wr = 4'b0010;
        step();
        flag_wr_valid = 1'b0;
        chk("full_both_pending", pending_q, 4);
        chk("full_both_err", err_sticky, 0);
        chk("full_both_flags", flags_q, 4'b0010);
        step();
        alu_issue = 1'b0;
        chk("oflow_pending", pending_q, 4);
        chk("oflow_err", err_sticky, 2'b10);

        // Asynchronous reset while a branch waits on two ops.
        rst = 1'b1; step(); rst = 1'b0; step();
        alu_issue = 1'b1;
        repeat (2) step();
        alu_issue = 1'b0;
        branch(3'b000);
        step();
        chk("pre_rst_br_ready", br_ready, 0);
        chk("pre_rst_pending", pending_q, 2);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        chk_reset_vals("after_rst");

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_branch_resolver
`default_nettype wire

// File: doc/alu_branch_resolver.md
# alu_branch_resolver

Consumes the flag stream produced by the 128-bit ALU's flag selectors (Z, C, N, V) and resolves conditional branches against it. It tracks how many issued flag-writing ALU ops are still in flight and holds each accepted branch until all older ops have written back. It returns a taken/not-taken result over a valid/ready handshake. It sits between the ALU flag write-back and the fetch/sequencer branch path.

## Interface
- MAX_PENDING, 4, maximum outstanding flag-writing ALU ops; counter width is $clog2(MAX_PENDING+1)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_issue  in  1  one flag-writing ALU op issued this cycle
- flag_wr_valid  in  1  flag write-back from the oldest in-flight op
- flag_wr  in  4  {v, n, c, z} written when flag_wr_valid
- br_valid  in  1  branch request valid
- br_cond  in  3  condition code
- br_ready  out  1  branch request accepted when br_valid && br_ready
- res_valid  out  1  result valid
- res_taken  out  1  1 = branch taken
- res_ready  in  1  consumer accepts result
- flags_q  out  4  architectural flag register {v, n, c, z}
- pending_q  out  $clog2(MAX_PENDING+1)  in-flight flag-writing ops
- err_sticky  out  2  {overflow, underflow}; sticky until reset

## Operation
- Condition codes:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 C
  - 100 !C
  - 101 N
  - 110 V
  - 111 never
- Flag register: flag_wr_valid loads flag_wr into flags_q.
- Pending counter: +1 on alu_issue, -1 on flag_wr_valid. Both in one cycle leaves it unchanged.
- Overflow: alu_issue without flag_wr_valid at pending_q == MAX_PENDING sets err_sticky[1]; the count saturates.
- Underflow: flag_wr_valid without alu_issue at pending_q == 0 sets err_sticky[0]. The count stays 0, but flags_q is still loaded.
- Ordering:
  - An alu_issue coincident with a branch accept is younger than the branch.
  - A flag_wr_valid coincident with a branch accept is older than the branch.
- FSM states IDLE, WAIT, RESP:
  - IDLE: br_ready = 1. On accept, wait_cnt <= pending_q - flag_wr_valid (floor 0), latch br_cond, go to WAIT.
  - WAIT: br_ready = 0. If wait_cnt == 0, evaluate latched cond against current flags_q, register res_taken, go to RESP. Else decrement wait_cnt on flag_wr_valid. alu_issue never touches wait_cnt.
  - RESP: res_valid = 1; res_taken stable. On res_ready, go to IDLE.
- Younger flag writes arriving in the same cycle as evaluation do not affect that evaluation, because flags_q is the pre-edge value.

## Timing
- Reset values: state IDLE, br_ready 1, res_valid 0, res_taken 0, flags_q 0, pending_q 0, wait_cnt 0, err_sticky 0.
- No pending ops: accept at cycle N, evaluate at N+1, res_valid at N+2. Latency is 2 cycles.
- k older ops pending: res_valid appears 2 cycles after the k-th subsequent flag_wr_valid edge.
- Throughput: at most one branch per 3 cycles; res_ready held low stalls indefinitely.
- br_ready is a pure function of state (no combinational path from br_valid).
- Reset mid-operation: asynchronous return to reset values; any in-flight branch is dropped and no result is produced.

## Structure
- Package alu_flags_pkg:
  - cond_e enum (8 codes above)
  - flags_t packed struct {v, n, c, z}
  - brs_state_e enum {IDLE, WAIT, RESP}
- Sub-module cond_eval: combinational, inputs cond_e and flags_t, output taken; reusable by the sequencer.
- Top level holds the FSM, pending counter, wait_cnt, flags_q and error flags.

## Test plan
- Reset, then flag_wr_valid with flag_wr=0001 at pending 0 -> err_sticky=01, flags_q=0001. Branch cond 001 -> res_valid 2 cycles after accept, res_taken=1.
- 3× alu_issue, then branch cond 010 -> held in WAIT. Write flags 0000, 0000, 0001 on separate cycles -> res_taken=0, 2 cycles after the third write.
- Branch accepted together with alu_issue at pending 0, and flags_q Z=0, cond 010 -> res_taken=1 (younger op ignored); pending_q=1.
- Result with res_ready low for 5 cycles -> res_valid and res_taken stable; br_ready=0 throughout. On res_ready -> IDLE next cycle.
- 5× alu_issue with MAX_PENDING=4 -> pending_q=4, err_sticky[1]=1. Simultaneous issue and write at 4 -> count unchanged, no new error.
- Assert rst while in WAIT with pending_q=2 -> next cycle all outputs at reset values, no res_valid pulse.
